// File: rtl/timer_control.sv
// Host register front-end and overflow flag/IRQ logic for the two OPL3 timers.
// Latency: a write or an overflow pulse sampled at edge N is visible on the outputs right after edge N.
// Backpressure: none; every write strobe and overflow pulse is consumed in the cycle it is presented.
module timer_control #(
    parameter int REG_TIMER_WIDTH = 8,
    parameter int REG_FILE_ADDR_W = 9
) (
    input  logic                       clk,
    input  logic                       ic_n,
    input  logic                       wr,
    input  logic [REG_FILE_ADDR_W-1:0] address,
    input  logic [7:0]                 din,
    input  logic                       timer1_overflow_pulse,
    input  logic                       timer2_overflow_pulse,
    output logic [REG_TIMER_WIDTH-1:0] timer1_reg,
    output logic [REG_TIMER_WIDTH-1:0] timer2_reg,
    output logic                       start_timer1,
    output logic                       start_timer2,
    output logic [7:0]                 status,
    output logic                       irq_n
);

    logic       bank0_wr;
    logic       ctrl_wr;
    logic       rst_flags;
    logic       mt1;
    logic       mt2;
    logic       ft1;
    logic       ft2;
    logic       irq;
    logic       ft1_next;
    logic       ft2_next;

    assign bank0_wr  = wr && !address[REG_FILE_ADDR_W-1];
    assign ctrl_wr   = bank0_wr && (address[7:0] == 8'h04);
    assign rst_flags = ctrl_wr && din[7];

    // Set wins over clear so an overflow coinciding with RST is never lost;
    // the mask in force before this cycle's write gates the pulse.
    assign ft1_next = (ft1 && !rst_flags) || (timer1_overflow_pulse && !mt1);
    assign ft2_next = (ft2 && !rst_flags) || (timer2_overflow_pulse && !mt2);

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            timer1_reg   <= '0;
            timer2_reg   <= '0;
            start_timer1 <= 1'b0;
            start_timer2 <= 1'b0;
            mt1          <= 1'b0;
            mt2          <= 1'b0;
        end else if (bank0_wr) begin
            case (address[7:0])
                8'h02: timer1_reg <= din[REG_TIMER_WIDTH-1:0];
                8'h03: timer2_reg <= din[REG_TIMER_WIDTH-1:0];
                8'h04: begin
                    if (!din[7]) begin
                        mt1          <= din[6];
                        mt2          <= din[5];
                        start_timer2 <= din[1];
                        start_timer1 <= din[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge ic_n) begin
        if (!ic_n) begin
            ft1 <= 1'b0;
            ft2 <= 1'b0;
            irq <= 1'b0;
        end else begin
            ft1 <= ft1_next;
            ft2 <= ft2_next;
            irq <= ft1_next || ft2_next;
        end
    end

    assign status = {irq, ft1, ft2, 5'b0};
    assign irq_n  = !irq;

endmodule
